// File: rtl/rr_arb_mux_4_pkg.sv
// Shared types, constants and the round-robin pick helper for rr_arb_mux_4.
// Optional build macro: RR_FIXED_PRIORITY_EN (see rr_arb_mux_4.sv).
package rr_arb_pkg;

  typedef logic [1:0] sel_t;

  localparam int   N_IN       = 4;
  // Pointer value after reset: scanning starts just after it, so input 0 wins first.
  localparam sel_t RESET_LAST = 2'd3;

  // First asserted request scanning last+1, last+2, last+3, last (mod 4).
  // Returns 'last' when no request is asserted; callers gate on |req.
  function automatic sel_t rr_pick(logic [3:0] req, sel_t last);
    sel_t idx;
    sel_t pick;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = last + sel_t'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb_mux_4_if.sv
// Stream bundle for rr_arb_mux_4: four requesters in, one registered stream out.
// slave = arbiter's view, master = the environment driving it.
interface rr_arb_mux_4_if #(
  parameter int W = 4
);
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux_4_mux.sv
// Plain combinational 4:1 selection stage for 4-bit words.
module mux_4_1 (
  input  logic [1:0] i_sel,
  input  logic [3:0] i_d0,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d3,
  output logic [3:0] o_y
);

  // Select one of the four words by index.
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_arb_mux_4.sv
// rr_arb_mux_4: 4-input round-robin stream arbiter feeding a registered 4:1 mux.
// One word per cycle can be accepted; the winning index is registered with it.
// Build macro RR_FIXED_PRIORITY_EN: when defined, the lowest-index requester
// always wins and the round-robin pointer stays at its reset value.
module rr_arb_mux_4
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input logic          clk,
  input logic          rst,
  rr_arb_mux_4_if.slave bus
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  sel_t         r_out_sel;
  sel_t         r_last;

  logic         w_load_ok;
  logic         w_grant;
  sel_t         w_grant_idx;
  logic [3:0]   w_in_ready;
  logic [W-1:0] w_mux_data;

  // Grant decision: the output register can take a word when empty or being drained.
  // With the pointer pinned at RESET_LAST the scan starts at input 0, which is
  // exactly fixed lowest-index priority, so one pick function serves both modes.
  always_comb begin
    w_load_ok   = !r_out_valid | bus.out_ready;
    w_grant     = w_load_ok & (|bus.in_valid) & !rst;
    w_grant_idx = rr_pick(bus.in_valid, r_last);
    w_in_ready  = '0;
    if (w_grant) begin
      w_in_ready[w_grant_idx] = 1'b1;
    end
  end

  // Data path: the grant index drives the select of the 4:1 stage directly.
  generate
    if (W == 4) begin : g_mux_inst
      mux_4_1 u_mux (
        .i_sel (w_grant_idx),
        .i_d0  (bus.d0),
        .i_d1  (bus.d1),
        .i_d2  (bus.d2),
        .i_d3  (bus.d3),
        .o_y   (w_mux_data)
      );
    end else begin : g_mux_inline
      logic [W-1:0] w_words [N_IN];
      assign w_words[0] = bus.d0;
      assign w_words[1] = bus.d1;
      assign w_words[2] = bus.d2;
      assign w_words[3] = bus.d3;
      // Generic-width selection for non-4-bit builds.
      always_comb begin
        w_mux_data = w_words[w_grant_idx];
      end
    end
  endgenerate

  // Output register: load on a grant, drop valid when drained without a refill,
  // otherwise hold (covers the stall case and keeps stale data/sel after a drain).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_sel   <= w_grant_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: moves only on a grant; idle and stalled cycles keep it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= RESET_LAST;
`ifdef RR_FIXED_PRIORITY_EN
    end else begin
      r_last <= RESET_LAST;
`else
    end else if (w_grant) begin
      r_last <= w_grant_idx;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule
